// File: rtl/fetch_unit.sv
// Instruction fetch unit: a three-state handshake FSM that requests a word from
// instruction memory, holds it for the controller, and advances the pc on accept.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7,
    input  logic        pc_src,
    input  logic [31:0] branch_target,
    output logic [31:0] pc,
    output logic        misalign_err,
    output logic [31:0] retire_count
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] pc_r;
    logic [31:0] pc_next_s;
    logic [31:0] instr_r;
    logic [31:0] count_r;
    logic        misalign_r;
    logic        capture_s;
    logic        accept_s;
    logic        misalign_hit_s;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode and handshake qualifiers
    always_comb begin
        state_next_s = state_r;
        capture_s    = 1'b0;
        accept_s     = 1'b0;
        case (state_r)
            IDLE: begin
                state_next_s = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    capture_s    = 1'b1;
                    state_next_s = VALID;
                end else begin
                    state_next_s = FETCH;
                end
            end
            VALID: begin
                if (instr_ready) begin
                    accept_s     = 1'b1;
                    state_next_s = FETCH;
                end else begin
                    state_next_s = VALID;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Next pc: a taken branch always fetches from the word-aligned target
    always_comb begin
        pc_next_s      = pc_r + 32'd4;
        misalign_hit_s = 1'b0;
        if (pc_src) begin
            pc_next_s      = {branch_target[31:2], 2'b00};
            misalign_hit_s = (branch_target[1:0] != 2'b00);
        end else begin
            pc_next_s      = pc_r + 32'd4;
            misalign_hit_s = 1'b0;
        end
    end

    // Instruction register, pc, retire counter and sticky misalignment flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r       <= RESET_PC;
            instr_r    <= NOP;
            count_r    <= 32'd0;
            misalign_r <= 1'b0;
        end else begin
            if (capture_s) begin
                instr_r <= imem_rdata;
            end
            if (accept_s) begin
                pc_r    <= pc_next_s;
                count_r <= count_r + 32'd1;
                if (misalign_hit_s) begin
                    misalign_r <= 1'b1;
                end
            end
        end
    end

    assign imem_req     = (state_r == FETCH);
    assign instr_valid  = (state_r == VALID);
    assign imem_addr    = pc_r;
    assign pc           = pc_r;
    assign instr        = instr_r;
    assign op           = instr_r[6:0];
    assign funct3       = instr_r[14:12];
    assign funct7       = instr_r[30];
    assign misalign_err = misalign_r;
    assign retire_count = count_r;

endmodule
